// File: rtl/dmem_responder.sv
// dmem_responder
// ----------------------------------------------------------------------------
// Memory end of the CPU load/store port. The block accepts one request at a
// time over a valid/ready channel. After WAIT_CYCLES wait states it answers
// with a one-cycle rsp_valid pulse. All state changes on the falling clock
// edge, so it stays in step with the CPU pipeline.
//
// Handshake: a request transfers at a falling edge where
// req_valid && req_ready. req_ready is a registered-state decode: it is high
// in IDLE and RESP and low in WAIT. The req_* inputs are ignored while
// req_ready is low, and nothing is queued. rsp_valid is high for exactly one
// cycle per accepted request. rsp_rdata and rsp_err are meaningful only
// while rsp_valid is high.
//
// Parameters:
//   DEPTH       - number of 32-bit words (power of two)
//   WAIT_CYCLES - wait states between acceptance and response (0..15)
//
// Ports:
//   clock      in   clock; state updates on the falling edge
//   reset      in   asynchronous, active-high
//   req_valid  in   request present
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address; word index = req_addr[log2(DEPTH)+1:2]
//   req_wdata  in   store data
//   req_ready  out  request can be accepted this cycle
//   rsp_valid  out  one-cycle completion pulse
//   rsp_rdata  out  load data (0 for stores and rejected accesses)
//   rsp_err    out  misaligned-access flag
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject accesses with
// req_addr[1:0] != 0. Such an access writes nothing, returns 0 and raises
// rsp_err. When the macro is not defined, the low address bits are ignored
// and rsp_err stays 0.
//
// Debug visibility: the FSM state is held in the signal `state`.
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;

    // Request captured at acceptance.
    logic            lat_write;
    logic [AW-1:0]   lat_idx;
    logic [31:0]     lat_wdata;
    logic            lat_mis;

    // The request that completes at this edge. It is the latched request,
    // unless there are zero wait states; then it is the live request.
    logic            commit;
    logic            c_write;
    logic [AW-1:0]   c_idx;
    logic [31:0]     c_wdata;
    logic            c_mis;

    logic            accept;
    logic            req_mis;
    logic            mem_we;
    logic            unused_addr;

    logic [31:0]     mem [DEPTH];

    assign req_ready = (state != WAIT);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_mis = (req_addr[1:0] != 2'b00);
`else
    assign req_mis = 1'b0;
`endif

    // Address bits above the array size alias. When the alignment check is
    // off, the low bits are ignored as well.
    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        c_write   = lat_write;
        c_idx     = lat_idx;
        c_wdata   = lat_wdata;
        c_mis     = lat_mis;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: this edge accepts the request
                        // and completes it.
                        state_nxt = RESP;
                        cnt_nxt   = 4'd0;
                        commit    = 1'b1;
                        c_write   = req_write;
                        c_idx     = req_addr[AW+1:2];
                        c_wdata   = req_wdata;
                        c_mis     = req_mis;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_mis   <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_write <= req_write;
                lat_idx   <= req_addr[AW+1:2];
                lat_wdata <= req_wdata;
                lat_mis   <= req_mis;
            end
            if (commit) begin
                rsp_err   <= c_mis;
                rsp_rdata <= (c_write || c_mis) ? 32'd0 : mem[c_idx];
            end
        end
    end

    // Stores commit at the edge that enters RESP. The reset gate keeps a
    // zero-wait request that is presented during reset out of the array.
    assign mem_we = commit && c_write && !c_mis && !reset;

    always_ff @(negedge clock) begin
        if (mem_we) begin
            mem[c_idx] <= c_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// ----------------------------------------------------------------------------
// Bench for dmem_responder. It runs two instances side by side:
//   u_w2 : WAIT_CYCLES = 2
//   u_w0 : WAIT_CYCLES = 0 (back-to-back operation)
// Both instances share the clock and reset. Each instance has its own
// request signals, reference memory and expected-response queue. The
// expected response and its arrival cycle are pushed when a request is
// driven. A posedge monitor pops and compares them when rsp_valid shows up.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] ref_mem [2][DEPTH];
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int          exp_cyc_q0[$];
  int          exp_cyc_q1[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(negedge clock) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic push_exp(input int d, input logic [32:0] e, input int c);
    if (d == 0) begin
      exp_q0.push_back(e);
      exp_cyc_q0.push_back(c);
    end else begin
      exp_q1.push_back(e);
      exp_cyc_q1.push_back(c);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive at a posedge, so the following negedge samples a stable request.
  // Return with the request still asserted, so consecutive calls give
  // back-to-back traffic.
  task automatic send(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int          waited;
    logic        mis;
    logic [9:0]  idx;
    logic [32:0] e;
    waited = 0;
    @(posedge clock);
    while (!req_ready[d] && waited < 50) begin
      req_valid[d] = 1'b0;
      @(posedge clock);
      waited++;
    end
    if (waited >= 50) check_eq("ready_timeout", 64'(req_ready[d]), 64'd1);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    idx = addr[11:2];
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    if (mis) begin
      e = {1'b1, 32'd0};
    end else if (wr) begin
      ref_mem[d][idx] = wdata;
      e = {1'b0, 32'd0};
    end else begin
      e = {1'b0, ref_mem[d][idx]};
    end
    push_exp(d, e, cyc + 1 + wait_of(d));
  endtask

  task automatic idle(input int d);
    @(posedge clock);
    req_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_size(0) != 0 || q_size(1) != 0) && n < 100) begin
      @(posedge clock);
      n++;
    end
    check_eq("drain_w2", 64'(q_size(0)), 64'd0);
    check_eq("drain_w0", 64'(q_size(1)), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic take_rsp(input int d);
    logic [32:0] e;
    int          c;
    if (q_size(d) == 0) begin
      if (rsp_valid[d]) check_eq($sformatf("unexpected_rsp%0d", d), 64'(rsp_valid[d]), 64'd0);
    end else begin
      if (d == 0) begin
        e = exp_q0[0];
        c = exp_cyc_q0[0];
      end else begin
        e = exp_q1[0];
        c = exp_cyc_q1[0];
      end
      if (rsp_valid[d] || c < cyc) begin
        if (d == 0) begin
          void'(exp_q0.pop_front());
          void'(exp_cyc_q0.pop_front());
        end else begin
          void'(exp_q1.pop_front());
          void'(exp_cyc_q1.pop_front());
        end
        if (!rsp_valid[d]) begin
          check_eq($sformatf("rsp_missing%0d", d), 64'(rsp_valid[d]), 64'd1);
        end else begin
          check_eq($sformatf("rsp_data%0d", d), 64'({rsp_err[d], rsp_rdata[d]}), 64'(e));
          check_eq($sformatf("rsp_cycle%0d", d), 64'(cyc), 64'(c));
        end
      end
    end
  endtask

  always @(posedge clock) begin
    if (!reset) begin
      take_rsp(0);
      take_rsp(1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] old2;
    int          d;
    int          nb;
    logic [31:0] a;

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = 32'd0;
      req_wdata[k] = 32'd0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[0][i] = 32'h1000 + 32'(i) * 3;
      ref_mem[1][i] = 32'h1000 + 32'(i) * 3;
    end
    ref_mem[0][0] = 32'd5;
    ref_mem[0][1] = 32'd7;
    ref_mem[1][0] = 32'd5;
    ref_mem[1][1] = 32'd7;
    for (int i = 0; i < DEPTH; i++) begin
      u_w2.mem[i] = ref_mem[0][i];
      u_w0.mem[i] = ref_mem[1][i];
    end

    repeat (2) @(posedge clock);
    check_eq("rst_ready", 64'(req_ready[0]), 64'd1);
    check_eq("rst_valid", 64'(rsp_valid[0]), 64'd0);
    check_eq("rst_rdata", 64'(rsp_rdata[0]), 64'd0);
    check_eq("rst_err", 64'(rsp_err[0]), 64'd0);
    check_eq("rst_state", 64'(u_w2.state), 64'd0);
    check_eq("rst_valid_w0", 64'(rsp_valid[1]), 64'd0);
    reset = 1'b0;

    // Load word0 with two wait states.
    send(0, 1'b0, 32'd0, 32'd0);
    idle(0);
    check_eq("wait1_ready", 64'(req_ready[0]), 64'd0);
    check_eq("wait1_valid", 64'(rsp_valid[0]), 64'd0);
    @(posedge clock);
    check_eq("wait2_ready", 64'(req_ready[0]), 64'd0);
    check_eq("wait2_valid", 64'(rsp_valid[0]), 64'd0);
    @(posedge clock);
    check_eq("resp_valid", 64'(rsp_valid[0]), 64'd1);
    check_eq("resp_rdata", 64'(rsp_rdata[0]), 64'd5);
    check_eq("resp_ready", 64'(req_ready[0]), 64'd1);
    @(posedge clock);
    check_eq("after_resp_valid", 64'(rsp_valid[0]), 64'd0);

    // Store then load, where the load is accepted in the response cycle.
    send(0, 1'b1, 32'd0, 32'd7);
    send(0, 1'b0, 32'd0, 32'd0);
    idle(0);
    drain();
    check_eq("st_word0", 64'(u_w2.mem[0]), 64'd7);
    check_eq("st_word1", 64'(u_w2.mem[1]), 64'd7);

    // Back-to-back with zero wait states.
    send(1, 1'b0, 32'd0, 32'd0);
    send(1, 1'b0, 32'd4, 32'd0);
    send(1, 1'b0, 32'd8, 32'd0);
    send(1, 1'b0, 32'd12, 32'd0);
    send(1, 1'b1, 32'd16, 32'hdead_beef);
    send(1, 1'b0, 32'd16, 32'd0);
    idle(1);
    drain();
    check_eq("b2b_word4", 64'(u_w0.mem[4]), 64'hdead_beef);

    // Address wrap.
    send(0, 1'b1, 32'd4096, 32'h0000_00a5);
    send(0, 1'b0, 32'd0, 32'd0);
    idle(0);
    drain();
    check_eq("wrap_word0", 64'(u_w2.mem[0]), 64'ha5);
    send(1, 1'b1, 32'hffff_f000 + 32'd8, 32'h0000_005a);
    send(1, 1'b0, 32'd8, 32'd0);
    idle(1);
    drain();

    // Reset while a store is waiting. The store must not commit.
    old2 = ref_mem[0][2];
    send(0, 1'b1, 32'd8, 32'd9);
    ref_mem[0][2] = old2;
    @(posedge clock);
    req_valid[0] = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("midrst_ready", 64'(req_ready[0]), 64'd1);
    check_eq("midrst_valid", 64'(rsp_valid[0]), 64'd0);
    exp_q0.delete();
    exp_cyc_q0.delete();
    @(posedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      check_eq("midrst_no_rsp", 64'(rsp_valid[0]), 64'd0);
    end
    check_eq("midrst_word2", 64'(u_w2.mem[2]), 64'(old2));

    // Misaligned store and load.
    send(0, 1'b1, 32'd6, 32'd1);
    idle(0);
    drain();
`ifdef DMEM_ALIGN_CHECK_EN
    check_eq("mis_word1", 64'(u_w2.mem[1]), 64'd7);
`else
    check_eq("mis_word1", 64'(u_w2.mem[1]), 64'd1);
`endif
    send(0, 1'b0, 32'd5, 32'd0);
    idle(0);
    drain();

    // Random mixed traffic.
    for (int it = 0; it < 40; it++) begin
      d  = $urandom_range(0, 1);
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) begin
        a = {22'(0), 6'($urandom_range(0, 63)), 2'b00};
        if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom_range(1, 1000));
        send(d, 1'($urandom_range(0, 1)), a, $urandom);
      end
      idle(d);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
